// File: rtl/store_write_buffer.sv
// In-order store buffer: captures SW requests, drains them to the memory write port over req/ack, forwards to loads.
// mem_we rises one cycle after the first enqueue into an empty buffer; stall holds the core while all entries are pending.
`timescale 1ns/1ps

`ifndef STATE_DM
`define STATE_DM 3'd3
`endif
`ifndef OP_SW
`define OP_SW 6'h2b
`endif

module store_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MEM_SIZE = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack,
  output logic              empty,
  output logic              addr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  ONE_PTR  = PTR_W'(1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(MEM_SIZE);

  typedef enum logic {IDLE, WRITE} drain_t;

  drain_t            drain_st;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  next_rd;
  logic [PTR_W-1:0]  fwd_idx;
  logic [CNT_W-1:0]  count;
  logic              store_req;
  logic              in_range;
  logic              full;
  logic              push;
  logic              pop;

  assign store_req = (state == `STATE_DM) && (opcode == `OP_SW);
  assign in_range  = {1'b0, data_addr} < ADDR_LIM;
  assign full      = (count == FULL_CNT);
  assign push      = store_req && !full && in_range;
  assign pop       = (drain_st == WRITE) && mem_wack;
  assign next_rd   = rd_ptr + ONE_PTR;
  assign stall     = full && store_req;
  assign empty     = (count == '0);

  // Payload storage needs no reset; valid_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= data_addr;
      data_q[wr_ptr] <= store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      valid_q  <= '0;
      addr_err <= 1'b0;
    end else begin
      // push and pop never target the same slot: pop needs count > 0, push needs count < DEPTH
      if (pop) begin
        rd_ptr          <= next_rd;
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + ONE_PTR;
        valid_q[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (store_req && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_st  <= IDLE;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      case (drain_st)
        IDLE: begin
          if (count != '0) begin
            drain_st  <= WRITE;
            mem_we    <= 1'b1;
            mem_waddr <= addr_q[rd_ptr];
            mem_wdata <= data_q[rd_ptr];
          end
        end
        WRITE: begin
          if (mem_wack) begin
            if (count > ONE_CNT) begin
              mem_waddr <= addr_q[next_rd];
              mem_wdata <= data_q[next_rd];
            end else if (push) begin
              // The only remaining entry is the one being enqueued now; take it from the inputs.
              mem_waddr <= data_addr;
              mem_wdata <= store_data;
            end else begin
              mem_we   <= 1'b0;
              drain_st <= IDLE;
            end
          end
        end
        default: begin
          drain_st <= IDLE;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

  // Walk oldest to youngest so the last match found is the newest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == data_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: vector table plus hand sequences for stall, drain, wrap, bypass and reset.
`timescale 1ns/1ps

`ifndef STATE_DM
`define STATE_DM 3'd3
`endif
`ifndef OP_SW
`define OP_SW 6'h2b
`endif
`ifndef OP_LW
`define OP_LW 6'h23
`endif

module tb_store_write_buffer;

  localparam logic [2:0] S_DM  = `STATE_DM;
  localparam logic [2:0] S_ID  = 3'd0;
  localparam logic [5:0] O_SW  = `OP_SW;
  localparam logic [5:0] O_LW  = `OP_LW;
  localparam logic [5:0] O_NO  = 6'h00;

  logic       clk;
  logic       rst_n;
  logic [2:0] state;
  logic [5:0] opcode;
  logic [7:0] data_addr;
  logic [7:0] store_data;
  logic       stall;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_wack;
  logic       empty;
  logic       addr_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];

  store_write_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8), .MEM_SIZE(11)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .opcode(opcode),
    .data_addr(data_addr), .store_data(store_data), .stall(stall),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
    .empty(empty), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [5:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ack;
    logic       e_stall;
    logic       e_empty;
    logic       e_we;
    logic [7:0] e_waddr;
    logic [7:0] e_wdata;
    logic       e_hit;
    logic [7:0] e_fdata;
    logic       e_err;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [5:0] o, input logic [7:0] a,
                       input logic [7:0] d, input logic k);
    state      = s;
    opcode     = o;
    data_addr  = a;
    store_data = d;
    mem_wack   = k;
  endtask

  // Records every write the memory accepts, then advances to the next falling edge.
  task automatic step();
    #1;
    if (mem_we && mem_wack) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && (mem_we || !empty); n++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int gap;
    int dropped;

    //          st    op    addr   data   ack  stall empty we   waddr  wdata  hit  fdata  err
    vecs[0]  = '{S_ID, O_NO, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{S_DM, O_SW, 8'h03, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{S_ID, O_NO, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{S_ID, O_LW, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h55, 1'b1, 8'h55, 1'b0};
    vecs[4]  = '{S_ID, O_NO, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h55, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{S_ID, O_NO, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h55, 1'b1, 8'h55, 1'b0};
    vecs[6]  = '{S_ID, O_NO, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h55, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{S_ID, O_NO, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h55, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{S_DM, O_SW, 8'h05, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h55, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{S_DM, O_SW, 8'h05, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h55, 1'b1, 8'h11, 1'b0};
    vecs[10] = '{S_DM, O_LW, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 1'b1, 8'h22, 1'b0};
    vecs[11] = '{S_DM, O_LW, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{S_ID, O_LW, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11, 1'b1, 8'h22, 1'b0};
    vecs[13] = '{S_ID, O_LW, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h22, 1'b1, 8'h22, 1'b0};
    vecs[14] = '{S_ID, O_LW, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h22, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{S_DM, O_SW, 8'h0b, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h22, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{S_DM, O_SW, 8'h0a, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h22, 1'b0, 8'h00, 1'b1};
    vecs[17] = '{S_ID, O_LW, 8'h0a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h22, 1'b1, 8'h66, 1'b1};
    vecs[18] = '{S_ID, O_LW, 8'h0a, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0a, 8'h66, 1'b1, 8'h66, 1'b1};
    vecs[19] = '{S_ID, O_LW, 8'h0a, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0a, 8'h66, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0;
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset.stall", stall, 0);
    chk("reset.empty", empty, 1);
    chk("reset.we", mem_we, 0);
    chk("reset.waddr", mem_waddr, 0);
    chk("reset.wdata", mem_wdata, 0);
    chk("reset.hit", fwd_hit, 0);
    chk("reset.fdata", fwd_data, 0);
    chk("reset.err", addr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single store, forwarding and out-of-range cases
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].st, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ack);
      #1;
      chk($sformatf("v%0d.stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d.empty", i), empty, vecs[i].e_empty);
      chk($sformatf("v%0d.we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d.waddr", i), mem_waddr, vecs[i].e_waddr);
      chk($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d.hit", i), fwd_hit, vecs[i].e_hit);
      chk($sformatf("v%0d.fdata", i), fwd_data, vecs[i].e_fdata);
      chk($sformatf("v%0d.err", i), addr_err, vecs[i].e_err);
      step();
    end

    // Fill to DEPTH with ack low, then a fifth store stalls until the first ack
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(S_DM, O_SW, 8'(i), 8'hA0 + 8'(i), 1'b0);
      #1;
      chk("fill.stall_low", stall, 0);
      step();
    end
    drive(S_DM, O_SW, 8'h04, 8'hA4, 1'b0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("fill.stall_high", stall, 1);
      chk("fill.we_held", mem_we, 1);
      chk("fill.waddr_held", mem_waddr, 0);
      step();
    end
    drive(S_DM, O_SW, 8'h04, 8'hA4, 1'b1);
    #1;
    chk("fill.stall_on_pop", stall, 1);
    step();
    #1;
    chk("fill.stall_released", stall, 0);
    chk("fill.next_head", mem_waddr, 1);
    step();
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    drain(20);
    chk("fill.empty", empty, 1);
    chk("fill.we_low", mem_we, 0);
    chk("fill.count", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      chk($sformatf("fill.order%0d.addr", i), log_addr[i], i);
      chk($sformatf("fill.order%0d.data", i), log_data[i], 8'hA0 + 8'(i));
    end

    // Three queued stores drain on consecutive cycles with ack held high
    clear_log();
    for (int i = 0; i < 3; i++) begin
      drive(S_DM, O_SW, 8'h07 + 8'(i), 8'hB7 + 8'(i), 1'b0);
      step();
    end
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    wc = 0;
    gap = 0;
    dropped = 0;
    for (int n = 0; n < 8; n++) begin
      if (mem_we) begin
        wc++;
        if (dropped != 0) gap = 1;
      end else if (wc > 0) begin
        dropped = 1;
      end
      step();
    end
    chk("b2b.we_cycles", wc, 3);
    chk("b2b.gap", gap, 0);
    chk("b2b.count", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk($sformatf("b2b.order%0d", i), log_addr[i], 8'h07 + 8'(i));
    end

    // Ten stores with ack tied high wrap the pointers several times
    clear_log();
    for (int i = 0; i < 10; i++) begin
      drive(S_DM, O_SW, 8'(i), 8'h30 + 8'(i), 1'b1);
      #1;
      chk("wrap.stall", stall, 0);
      step();
    end
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    drain(20);
    chk("wrap.empty", empty, 1);
    chk("wrap.count", log_addr.size(), 10);
    for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
      chk($sformatf("wrap.order%0d.addr", i), log_addr[i], i);
      chk($sformatf("wrap.order%0d.data", i), log_data[i], 8'h30 + 8'(i));
    end

    // Store arriving as the last pending write is acked becomes the next head directly
    clear_log();
    drive(S_DM, O_SW, 8'h01, 8'hC1, 1'b1);
    step();
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    step();
    drive(S_DM, O_SW, 8'h02, 8'hC2, 1'b1);
    step();
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    drain(10);
    chk("bypass.count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("bypass.addr0", log_addr[0], 8'h01);
      chk("bypass.data0", log_data[0], 8'hC1);
      chk("bypass.addr1", log_addr[1], 8'h02);
      chk("bypass.data1", log_data[1], 8'hC2);
    end

    // Reset between edges while a write is outstanding
    clear_log();
    drive(S_DM, O_SW, 8'h01, 8'hD1, 1'b0);
    step();
    drive(S_DM, O_SW, 8'h02, 8'hD2, 1'b0);
    step();
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rst.we_before", mem_we, 1);
    chk("rst.err_before", addr_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.we_async", mem_we, 0);
    chk("rst.empty_async", empty, 1);
    chk("rst.err_cleared", addr_err, 0);
    chk("rst.waddr_cleared", mem_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(S_ID, O_NO, 8'h00, 8'h00, 1'b1);
    for (int n = 0; n < 6; n++) step();
    chk("rst.no_replay", log_addr.size(), 0);
    chk("rst.we_after", mem_we, 0);
    chk("rst.empty_after", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart of the load-only data memory port in the multi-cycle processor.
- Captures SW requests issued in the data-memory state into a small in-order FIFO, then drains them to the data-memory array write port over a req/ack handshake.
- Forwards buffered data to loads that hit a pending address, so a LW after a SW always returns the newest value.
- Stalls the processor when full.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, 2..16).
- ADDR_W, 8, data address width.
- DATA_W, 8, data word width.
- MEM_SIZE, 11, number of valid memory words; legal addresses are 0..MEM_SIZE-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- state  in  3  processor state; a store is accepted only when state == `STATE_DM.
- opcode  in  6  current instruction opcode; a store is identified by opcode == `OP_SW.
- data_addr  in  ADDR_W  store address, or load address used for forwarding lookup.
- store_data  in  DATA_W  value to store.
- stall  out  1  buffer full; the processor holds in `STATE_DM.
- fwd_hit  out  1  combinational: a valid buffered entry matches data_addr.
- fwd_data  out  DATA_W  combinational: data of the youngest matching entry; 0 when no hit.
- mem_we  out  1  registered write request to the memory array.
- mem_waddr  out  ADDR_W  registered write address, stable while mem_we = 1.
- mem_wdata  out  DATA_W  registered write data, stable while mem_we = 1.
- mem_wack  in  1  memory accepted the write this cycle; sampled only while mem_we = 1.
- empty  out  1  no buffered stores; the processor uses it as a drain-complete fence.
- addr_err  out  1  sticky: a store to an address >= MEM_SIZE was dropped.

Behaviour:
- Reset (async, rst_n = 0):
  - count = 0; rd_ptr = wr_ptr = 0; all valid bits cleared; drain FSM = IDLE.
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0, addr_err = 0.
  - Derived outputs: stall = 0, empty = 1, fwd_hit = 0, fwd_data = 0.
  - Reset asserted mid-write drops mem_we immediately and discards all pending stores; nothing is replayed after release.
- Enqueue:
  - Condition: posedge with state == `STATE_DM, opcode == `OP_SW, count < DEPTH, data_addr < MEM_SIZE.
  - Action: entry written at wr_ptr, valid set, wr_ptr incremented modulo DEPTH, count incremented.
  - Out of range: data_addr >= MEM_SIZE drops the store, sets addr_err, and leaves count unchanged.
- stall:
  - stall = (count == DEPTH) and a store is presented; decoded combinationally from registered count.
  - A pop in the same cycle does not admit the store; it is accepted the following cycle.
- Drain FSM:
  - IDLE: if count > 0, load mem_waddr/mem_wdata from head, set mem_we = 1, go to WRITE. mem_we rises exactly one cycle after the first enqueue into an empty buffer.
  - WRITE: hold mem_we and data until mem_wack = 1. On ack: pop head (valid cleared, rd_ptr+1, count-1).
    - If count after pop > 0, load the next head and stay in WRITE (back-to-back writes, no bubble).
    - Otherwise drop mem_we and go to IDLE.
  - Ack while mem_we = 0 is ignored.
- Simultaneous enqueue and pop: count is unchanged; both pointers advance; wrap-around is modulo DEPTH.
- Forwarding:
  - Compare data_addr against all valid entries, including the head being written.
  - The youngest match, by age from rd_ptr, wins.
  - Active regardless of opcode; the consumer uses it only for `OP_LW.
  - An entry enqueued on this posedge is visible from the next cycle.
- Ordering: writes reach memory in program order; same-address stores are never merged.
- empty = (count == 0).

Test Plan:
- Single store: SW addr 3, data 0x55 -> mem_we high one cycle later with addr 3/0x55; ack after 2 cycles -> mem_we low next cycle, empty = 1.
- Fill and stall, DEPTH = 4, ack held low: SW to addrs 0, 1, 2, 3 -> count 4; fifth SW addr 4 -> stall = 1 until first ack; then addr 4 is accepted and the writes drain in order 0, 1, 2, 3, 4.
- Forwarding: SW addr 5 = 0x11, then SW addr 5 = 0x22, ack low, LW addr 5 -> fwd_hit = 1, fwd_data = 0x22; LW addr 6 -> fwd_hit = 0, fwd_data = 0.
- Back-to-back drain with ack tied high: 3 queued stores -> 3 consecutive mem_we cycles with no gap; wrap-around exercised by 10 stores with DEPTH = 4.
- Out of range: SW addr 11, MEM_SIZE = 11 -> not enqueued, addr_err = 1 and sticky; a subsequent SW addr 10 is accepted normally.
- Reset mid-write: 2 stores queued, mem_we high, pull rst_n low between clock edges -> mem_we = 0 and empty = 1 asynchronously; no writes after release.
